// File: rtl/egress_stream_arbiter.sv
// Per-packet round-robin arbiter merging processor egress packets with serialized cycle counts.
// Define TAG_HEADER_EN to prefix every output packet with a source tag byte.
module egress_stream_arbiter #(
    parameter int         CYCLE_WIDTH    = 32,
    parameter logic [7:0] PACKET_TAG     = 8'h50,
    parameter logic [7:0] CYCLES_TAG     = 8'h43,
    parameter bit         START_PRIORITY = 1'b0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [7:0]             packet_in_data,
    input  logic                   packet_in_valid,
    output logic                   packet_in_ready,
    input  logic                   packet_in_last,
    input  logic [CYCLE_WIDTH-1:0] cycles_data,
    input  logic                   cycles_valid,
    output logic                   cycles_ready,
    output logic [7:0]             packet_out_data,
    output logic                   packet_out_valid,
    input  logic                   packet_out_ready,
    output logic                   packet_out_last
);

    localparam int NUM_BYTES = CYCLE_WIDTH / 8;
    localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        FORWARD = 2'd2,
        CYCLES  = 2'd3
    } state_t;

    state_t                 state;
    logic                   prio;  // 0: processor packets favoured, 1: cycle count favoured
    logic [CYCLE_WIDTH-1:0] cycles_shift;
    logic [IDX_W-1:0]       byte_idx;
    logic                   grant_packet;
    logic                   grant_cycles;

`ifdef TAG_HEADER_EN
    logic hdr_cycles;
`else
    logic [15:0] unused_tags;
    assign unused_tags = {PACKET_TAG, CYCLES_TAG};
`endif

    // A grant is only issued from IDLE and never while reset is held.
    always_comb begin
        grant_packet = 1'b0;
        grant_cycles = 1'b0;
        if (state == IDLE && !reset) begin
            if (packet_in_valid && (!cycles_valid || !prio))
                grant_packet = 1'b1;
            else if (cycles_valid)
                grant_cycles = 1'b1;
        end
    end

    assign cycles_ready = grant_cycles;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            prio     <= START_PRIORITY;
            byte_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_packet || grant_cycles) begin
                        prio     <= grant_packet;
                        byte_idx <= '0;
`ifdef TAG_HEADER_EN
                        hdr_cycles <= grant_cycles;
                        state      <= HEADER;
`else
                        state <= grant_packet ? FORWARD : CYCLES;
`endif
                    end
                end
`ifdef TAG_HEADER_EN
                HEADER: begin
                    if (packet_out_ready)
                        state <= hdr_cycles ? CYCLES : FORWARD;
                end
`endif
                FORWARD: begin
                    if (packet_in_valid && packet_out_ready && packet_in_last)
                        state <= IDLE;
                end
                CYCLES: begin
                    if (packet_out_ready) begin
                        if (byte_idx == LAST_IDX) begin
                            byte_idx <= '0;
                            state    <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Count is captured on grant and shifted MSB-first; it only moves on an accepted byte.
    always_ff @(posedge clock) begin
        if (grant_cycles)
            cycles_shift <= cycles_data;
        else if (state == CYCLES && packet_out_ready)
            cycles_shift <= cycles_shift << 8;
    end

    always_comb begin
        packet_out_data  = '0;
        packet_out_valid = 1'b0;
        packet_out_last  = 1'b0;
        packet_in_ready  = 1'b0;
        case (state)
            FORWARD: begin
                packet_out_data  = packet_in_data;
                packet_out_valid = packet_in_valid;
                packet_out_last  = packet_in_last;
                packet_in_ready  = packet_out_ready;
            end
            CYCLES: begin
                packet_out_data  = cycles_shift[CYCLE_WIDTH-1 -: 8];
                packet_out_valid = 1'b1;
                packet_out_last  = (byte_idx == LAST_IDX);
            end
`ifdef TAG_HEADER_EN
            HEADER: begin
                packet_out_data  = hdr_cycles ? CYCLES_TAG : PACKET_TAG;
                packet_out_valid = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_egress_stream_arbiter.sv
// Scoreboard bench for egress_stream_arbiter: packet-level round-robin model feeds an
// expected-byte queue, an independent monitor checks every accepted output byte.
`timescale 1ns/1ps
module tb_egress_stream_arbiter;

    localparam int         CW        = 32;
    localparam int         NB        = CW / 8;
    localparam bit         START_PRI = 1'b0;
    localparam logic [7:0] P_TAG     = 8'h50;
    localparam logic [7:0] C_TAG     = 8'h43;

    logic          clock = 1'b0;
    logic          reset;
    logic [7:0]    packet_in_data;
    logic          packet_in_valid;
    logic          packet_in_ready;
    logic          packet_in_last;
    logic [CW-1:0] cycles_data;
    logic          cycles_valid;
    logic          cycles_ready;
    logic [7:0]    packet_out_data;
    logic          packet_out_valid;
    logic          packet_out_ready;
    logic          packet_out_last;

    always #5 clock = ~clock;

    egress_stream_arbiter #(
        .CYCLE_WIDTH(CW),
        .PACKET_TAG(P_TAG),
        .CYCLES_TAG(C_TAG),
        .START_PRIORITY(START_PRI)
    ) dut (
        .clock(clock),
        .reset(reset),
        .packet_in_data(packet_in_data),
        .packet_in_valid(packet_in_valid),
        .packet_in_ready(packet_in_ready),
        .packet_in_last(packet_in_last),
        .cycles_data(cycles_data),
        .cycles_valid(cycles_valid),
        .cycles_ready(cycles_ready),
        .packet_out_data(packet_out_data),
        .packet_out_valid(packet_out_valid),
        .packet_out_ready(packet_out_ready),
        .packet_out_last(packet_out_last)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [8:0] exp_q[$];          // {last, data}
    int         cyc_pulses = 0;
    int         ready_mode = 0;    // 0 always, 1 random, 2 toggle, 3 sparse (long stalls)
    bit         favour_cycles = START_PRI;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired, expected completion", name);
    endtask

    // Downstream ready generator
    initial begin
        packet_out_ready = 1'b0;
        forever begin
            @(negedge clock);
            case (ready_mode)
                0:       packet_out_ready = 1'b1;
                1:       packet_out_ready = ($urandom_range(0, 2) != 0);
                2:       packet_out_ready = ~packet_out_ready;
                default: packet_out_ready = ($urandom_range(0, 5) == 0);
            endcase
        end
    end

    // Monitor: pops expectations on every output transfer, plus protocol checks
    logic [8:0] mon_e;
    logic [8:0] prev_out;
    logic       prev_hold;
    logic       prev_last_xfer;
    initial begin
        prev_hold = 1'b0;
        prev_last_xfer = 1'b0;
        prev_out = '0;
        forever begin
            @(negedge clock);
            #1;
            if (reset) begin
                prev_hold = 1'b0;
                prev_last_xfer = 1'b0;
            end else begin
                if (cycles_ready) begin
                    cyc_pulses++;
                    check("cycles_ready_without_valid", cycles_valid, 1);
                end
                if (prev_last_xfer)
                    check("bubble_after_last", packet_out_valid, 0);
                if (prev_hold)
                    check("stalled_byte_hold", {packet_out_valid, packet_out_last, packet_out_data},
                          {1'b1, prev_out});
                if (packet_in_valid && packet_in_ready)
                    check("passthrough", {packet_out_valid, packet_out_ready, packet_out_last, packet_out_data},
                          {2'b11, packet_in_last, packet_in_data});
                if (packet_out_valid && packet_out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got %0h, expected no output", packet_out_data);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("out_byte", {packet_out_last, packet_out_data}, mon_e);
                    end
                end
                prev_last_xfer = packet_out_valid && packet_out_ready && packet_out_last;
                prev_hold = packet_out_valid && !packet_out_ready && !packet_in_valid;
                prev_out = {packet_out_last, packet_out_data};
            end
        end
    end

    task automatic push_pkt(input logic [7:0] b[$], input int n);
`ifdef TAG_HEADER_EN
        exp_q.push_back({1'b0, P_TAG});
`endif
        for (int i = 0; i < n; i++)
            exp_q.push_back({(i == b.size() - 1), b[i]});
    endtask

    task automatic push_cycles(input logic [CW-1:0] v);
`ifdef TAG_HEADER_EN
        exp_q.push_back({1'b0, C_TAG});
`endif
        for (int k = NB - 1; k >= 0; k--)
            exp_q.push_back({(k == 0), 8'(v >> (8 * k))});
    endtask

    // Drives the first stop_after bytes; the first byte is held valid until accepted.
    task automatic send_pkt(input logic [7:0] b[$], input int stop_after);
        int i = 0;
        int guard = 0;
        @(negedge clock);
        while (i < stop_after) begin
            if (i == 0 || $urandom_range(0, 3) != 0) begin
                packet_in_valid = 1'b1;
                packet_in_data  = b[i];
                packet_in_last  = (i == b.size() - 1);
            end else begin
                packet_in_valid = 1'b0;
                packet_in_data  = 8'($urandom);
                packet_in_last  = 1'($urandom_range(0, 1));
            end
            #1;
            if (packet_in_valid && packet_in_ready)
                i++;
            guard++;
            if (guard > 1000) begin
                fail_now("packet_accept_timeout");
                break;
            end
            @(negedge clock);
        end
        if (stop_after == b.size()) begin
            packet_in_valid = 1'b0;
            packet_in_last  = 1'b0;
        end
    endtask

    task automatic send_cycles(input logic [CW-1:0] v);
        int guard = 0;
        @(negedge clock);
        cycles_valid = 1'b1;
        cycles_data  = v;
        forever begin
            #1;
            if (cycles_ready)
                break;
            guard++;
            if (guard > 1000) begin
                fail_now("cycles_accept_timeout");
                break;
            end
            @(negedge clock);
        end
        @(negedge clock);
        cycles_valid = 1'b0;
        cycles_data  = CW'($urandom);
    endtask

    // The latched count must ignore cycles_data churn while it is being serialized.
    task automatic wait_drain();
        int guard = 0;
        while (exp_q.size() != 0) begin
            @(negedge clock);
            cycles_data = (guard == 0) ? 32'hDEADBEEF : CW'($urandom);
            guard++;
            if (guard > 500) begin
                fail_now("output_drain_timeout");
                exp_q.delete();
                break;
            end
        end
        @(negedge clock);
    endtask

    // Both requesters arrive together while idle; order follows the favoured source.
    task automatic run_round(input bit has_p, input bit has_c, input logic [7:0] b[$],
                             input logic [CW-1:0] v);
        cyc_pulses = 0;
        if (has_p && has_c) begin
            if (favour_cycles) begin
                push_cycles(v);
                push_pkt(b, b.size());
            end else begin
                push_pkt(b, b.size());
                push_cycles(v);
            end
        end else if (has_p) begin
            push_pkt(b, b.size());
            favour_cycles = 1'b1;
        end else begin
            push_cycles(v);
            favour_cycles = 1'b0;
        end
        fork
            if (has_p) send_pkt(b, b.size());
            if (has_c) send_cycles(v);
        join
        wait_drain();
        check("cycles_grant_count", cyc_pulses, has_c);
    endtask

    logic [7:0] pkt[$];
    initial begin
        reset           = 1'b1;
        packet_in_valid = 1'b1;
        packet_in_data  = 8'h5A;
        packet_in_last  = 1'b1;
        cycles_valid    = 1'b1;
        cycles_data     = 32'hCAFE0001;
        ready_mode      = 0;

        // Requests presented during reset must not be granted
        repeat (3) @(negedge clock);
        #1;
        check("reset_outputs", {packet_out_valid, packet_out_last, packet_out_data, packet_in_ready, cycles_ready}, 0);
        @(negedge clock);
        #1;
        check("reset_outputs_held", {packet_out_valid, packet_out_last, packet_out_data, packet_in_ready, cycles_ready}, 0);
        @(negedge clock);
        reset           = 1'b0;
        packet_in_valid = 1'b0;
        packet_in_last  = 1'b0;
        cycles_valid    = 1'b0;
        @(negedge clock);
        #1;
        check("idle_outputs", {packet_out_valid, packet_out_last, packet_out_data, packet_in_ready, cycles_ready}, 0);

        // Cycle count alone, always ready
        ready_mode = 0;
        pkt = {};
        run_round(1'b0, 1'b1, pkt, 32'h12345678);

        // Processor packet with toggling ready
        ready_mode = 2;
        pkt = {8'hAA, 8'hBB, 8'hCC};
        run_round(1'b1, 1'b0, pkt, '0);

        // Contention: favoured source first, then the other after a bubble
        ready_mode = 1;
        pkt = {8'h10, 8'h20};
        run_round(1'b1, 1'b1, pkt, 32'h0BADF00D);
        pkt = {8'h31};
        run_round(1'b1, 1'b0, pkt, '0);
        pkt = {8'h41, 8'h42, 8'h43};
        run_round(1'b1, 1'b1, pkt, 32'h01020304);

        // Long stalls mid-serialization with cycles_data changing underneath
        ready_mode = 3;
        pkt = {};
        run_round(1'b0, 1'b1, 32'h12345678 == 0 ? pkt : pkt, 32'h12345678);
        run_round(1'b0, 1'b1, pkt, 32'hDEADBEEF);

        // Reset in the middle of a forwarded packet
        ready_mode = 0;
        @(negedge clock);
        pkt = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        push_pkt(pkt, 2);
        send_pkt(pkt, 2);
        reset           = 1'b1;
        packet_in_valid = 1'b0;
        packet_in_last  = 1'b0;
        @(negedge clock);
        #1;
        check("reset_mid_packet_outputs", {packet_out_valid, packet_out_last, packet_out_data, packet_in_ready, cycles_ready}, 0);
        check("reset_mid_packet_drained", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
        favour_cycles = START_PRI;
        pkt = {8'h01};
        run_round(1'b1, 1'b0, pkt, '0);

        // Tag-sized values and single bytes
        pkt = {8'h11};
        run_round(1'b1, 1'b0, pkt, '0);
        pkt = {};
        run_round(1'b0, 1'b1, pkt, 32'h0000000A);

        // Randomized rounds
        for (int r = 0; r < 40; r++) begin
            bit hp;
            bit hc;
            int len;
            ready_mode = $urandom_range(0, 3);
            hp = 1'($urandom_range(0, 1));
            hc = 1'($urandom_range(0, 1));
            if (!hp && !hc) hp = 1'b1;
            len = $urandom_range(1, 6);
            pkt = {};
            for (int i = 0; i < len; i++)
                pkt.push_back(8'($urandom));
            run_round(hp, hc, pkt, CW'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

endmodule
